wb_scn_sequencer: RTL and testbench
===================================

Name: wb_scn_sequencer

Overview:
- Wishbone slave on the lm32 SoC bus, directly upstream of the static-screen draw engine.
- Accepts screen indices from software into a small command FIFO.
- Drives the engine's opt_scn/init_draw pair one screen at a time and watches done_draw to sequence the next one.
- Reports busy/level/error status and raises an optional completion interrupt.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of 2, range 2..16.
- INIT_CYCLES, 8: clk cycles init_draw is held high per launch; must be ≥1.
- TIMEOUT, 2000000: clk cycles allowed from launch to done_draw before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wb_adr_i  in  4  byte address; bits [3:2] select register
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid while wb_ack_o=1
- wb_sel_i  in  4  byte lanes; a write takes effect only if wb_sel_i[0]=1
- wb_we_i  in  1  write enable
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_ack_o  out  1  acknowledge
- opt_scn  out  4  screen index to the draw engine
- init_draw  out  1  launch/reset pulse to the draw engine
- done_draw  in  1  engine done level; asynchronous to clk (engine runs on its derived sck)
- irq  out  1  level interrupt

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, opt_scn=0, init_draw=0, irq=0. FIFO is empty, all sticky bits are clear, FSM is in IDLE.
- Bus access: wb_ack_o rises the cycle after wb_stb_i&wb_cyc_i&!wb_ack_o and stays high exactly one cycle. Writes commit in the ack cycle. Reads return zero in undefined bits.
- Register 0x0 CMD:
  - Write: pushes wb_dat_i[3:0].
  - Read: [3:0]=opt_scn.
- Register 0x4 STATUS (read):
  - bit0 busy (FSM≠IDLE), bit1 full, bit2 empty.
  - bit3 timeout_err, bit4 done_pend, bit5 overflow.
  - [11:8] FIFO level.
  - Writing 1 to bit3/4/5 clears that bit (W1C).
- Register 0x8 CTRL (read/write):
  - bit0 irq_en.
  - bit1 flush: self-clearing; empties the FIFO in the commit cycle and reads as 0.
- Register 0xC: see Optional Feature.
- irq = irq_en & (done_pend | timeout_err); registered.
- done_draw passes through a 2-flop synchronizer to give done_s.
- FSM:
  - IDLE: if FIFO is non-empty, pop the head into opt_scn and go to LAUNCH.
  - LAUNCH: init_draw=1 for INIT_CYCLES cycles, then go to WAIT_LOW.
  - WAIT_LOW: wait for done_s=0, which discards a stale done from the previous screen, then go to WAIT_DONE.
  - WAIT_DONE: wait for done_s=1, then go to COMPLETE.
  - COMPLETE: one cycle; set done_pend; go to IDLE.
- Timeout:
  - A counter clears on entry to LAUNCH and increments in LAUNCH, WAIT_LOW and WAIT_DONE.
  - On reaching TIMEOUT: set timeout_err, force init_draw=0, go to IDLE. done_pend is not set.
- opt_scn changes only on a pop; it is stable from LAUNCH through COMPLETE.
- Push to a full FIFO is dropped and sets overflow.
- Push and pop in the same cycle: both occur and the level is unchanged. This also applies when full: the push is accepted.
- Flush during a draw: the queued entries are discarded; the in-flight screen completes normally.
- Flush and push in the same cycle: flush wins and the push is dropped; overflow is not set.
- Reset mid-draw: init_draw drops asynchronously and the FIFO and sticky bits clear.
- Screen index wraps: 4-bit value, no range check.

Optional Feature:
- Macro: SCN_SLIDESHOW_EN.
- Defined:
  - 0xC PERIOD is a 24-bit read/write register, reset 0.
  - CTRL bit2 is auto_en.
  - When auto_en=1, PERIOD≠0, FSM is IDLE and the FIFO is empty, an idle counter runs.
  - When it reaches PERIOD, opt_scn←opt_scn+1 (mod 16), the FSM enters LAUNCH, and the counter clears.
  - The counter clears on any push or when leaving IDLE. FIFO entries always take priority.
- Not defined: 0xC reads 0 and ignores writes; CTRL bit2 reads 0; no auto launches.

Test Plan:
- Reset, push 0x3, done_draw model rises 500 clk after init_draw falls -> opt_scn=3, init_draw high exactly 8 cycles, done_pend=1, busy=0, 3-cycle sync latency observed.
- irq_en=1, push 1,2,3,4,5 with the engine stalled -> fifth push accepted only after the first pop. Pushing 5 entries before any pop sets overflow and leaves level=4. irq asserts after each completion until W1C.
- done_draw held high from the previous screen, then push 0x7 -> FSM waits in WAIT_LOW. No false completion until done falls and rises again.
- TIMEOUT=1000, engine never responds -> timeout_err=1 at cycle 1000 after launch, init_draw=0, next FIFO entry launched, irq if enabled.
- Flush while drawing screen 2 with 2 queued -> screen 2 completes, level=0, empty=1. Assert reset mid-WAIT_DONE -> all outputs return to reset values immediately.
- With SCN_SLIDESHOW_EN, PERIOD=100, auto_en=1, opt_scn=0xF -> after 100 idle cycles opt_scn=0x0 launched. A push during the idle count restarts the count and is served first.

Source files
------------

// File: rtl/wb_scn_sequencer.sv
// wb_scn_sequencer: Wishbone-controlled command FIFO that sequences screen
// draws on the static-screen engine via opt_scn/init_draw and done_draw.
// Optional slideshow auto-advance is built when SCN_SLIDESHOW_EN is defined.
module wb_scn_sequencer #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned INIT_CYCLES = 8,
   parameter int unsigned TIMEOUT     = 2000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   output logic [3:0]  opt_scn,
   output logic        init_draw,
   input  logic        done_draw,
   output logic        irq
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LW = AW + 1;
   localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT_LOW, S_WAIT_DONE, S_COMPLETE
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    opt_scn_q, opt_scn_d;
   logic [IW-1:0] lcnt_q, lcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          init_draw_q;
   logic          ack_q, irq_q, irq_en_q;
   logic [31:0]   dat_q, rdata_c;
   logic          err_q, pend_q, ovf_q;
   logic          done_meta_q, done_s_q;
   logic [3:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [LW-1:0] level_q;
   logic          pop_c, set_pend_c, set_err_c, auto_fire_c, auto_en_rd_c;
   logic [23:0]   period_rd_c;
   logic          unused_bits;

   // Bus decode: request opens a one-cycle ack; writes commit in the ack cycle
   logic       req_c, commit_c, wr_cmd_c, wr_stat_c, wr_ctrl_c, flush_c;
   logic       full_c, empty_c, push_ok_c;
   logic [1:0] reg_sel_c;
   assign req_c     = wb_stb_i & wb_cyc_i & ~ack_q;
   assign commit_c  = ack_q & wb_stb_i & wb_cyc_i & wb_we_i & wb_sel_i[0];
   assign reg_sel_c = wb_adr_i[3:2];
   assign wr_cmd_c  = commit_c & (reg_sel_c == 2'd0);
   assign wr_stat_c = commit_c & (reg_sel_c == 2'd1);
   assign wr_ctrl_c = commit_c & (reg_sel_c == 2'd2);
   assign flush_c   = wr_ctrl_c & wb_dat_i[1];
   assign full_c    = (level_q == LW'(FIFO_DEPTH));
   assign empty_c   = (level_q == '0);
   assign push_ok_c = wr_cmd_c & ~flush_c & (~full_c | pop_c);
   assign unused_bits = ^{wb_dat_i[31:6], wb_adr_i[1:0], wb_sel_i[3:1]};

   assign wb_ack_o  = ack_q;
   assign wb_dat_o  = dat_q;
   assign opt_scn   = opt_scn_q;
   assign init_draw = init_draw_q;
   assign irq       = irq_q;

`ifdef SCN_SLIDESHOW_EN
   logic        wr_per_c, auto_en_q;
   logic [23:0] period_q, idle_cnt_q;
   assign wr_per_c     = commit_c & (reg_sel_c == 2'd3);
   assign auto_fire_c  = auto_en_q & (period_q != '0) & (state_q == S_IDLE) & empty_c &
                         ~wr_cmd_c & (idle_cnt_q == period_q - 24'd1);
   assign auto_en_rd_c = auto_en_q;
   assign period_rd_c  = period_q;

   // Slideshow period/enable registers and idle-cycle counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         auto_en_q  <= 1'b0;
         period_q   <= '0;
         idle_cnt_q <= '0;
      end else begin
         if (wr_ctrl_c) auto_en_q <= wb_dat_i[2];
         if (wr_per_c)  period_q  <= wb_dat_i[23:0];
         if (wr_cmd_c || state_q != S_IDLE || state_d != S_IDLE || !auto_en_q ||
             period_q == '0 || !empty_c)
            idle_cnt_q <= '0;
         else
            idle_cnt_q <= idle_cnt_q + 24'd1;
      end
   end
`else
   assign auto_fire_c  = 1'b0;
   assign auto_en_rd_c = 1'b0;
   assign period_rd_c  = '0;
`endif

   // Two-flop synchronizer for the engine's done level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_meta_q <= 1'b0;
         done_s_q    <= 1'b0;
      end else begin
         done_meta_q <= done_draw;
         done_s_q    <= done_meta_q;
      end
   end

   // FIFO storage (no reset needed; validity tracked by level)
   always_ff @(posedge clk) begin
      if (push_ok_c) mem_q[wr_ptr_q] <= wb_dat_i[3:0];
   end

   // FIFO pointers and level; flush discards everything queued
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush_c) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_c)     rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok_c, pop_c})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Sequencer next-state: launch, drain stale done, await done, complete
   always_comb begin
      state_d    = state_q;
      opt_scn_d  = opt_scn_q;
      lcnt_d     = lcnt_q;
      tcnt_d     = tcnt_q;
      pop_c      = 1'b0;
      set_pend_c = 1'b0;
      set_err_c  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty_c) begin
               pop_c     = 1'b1;
               opt_scn_d = mem_q[rd_ptr_q];
               state_d   = S_LAUNCH;
               lcnt_d    = '0;
               tcnt_d    = '0;
            end else if (auto_fire_c) begin
               opt_scn_d = opt_scn_q + 4'd1;
               state_d   = S_LAUNCH;
               lcnt_d    = '0;
               tcnt_d    = '0;
            end
         end
         S_LAUNCH: begin
            lcnt_d = lcnt_q + IW'(1);
            if (lcnt_q == IW'(INIT_CYCLES - 1)) state_d = S_WAIT_LOW;
         end
         S_WAIT_LOW:  if (!done_s_q) state_d = S_WAIT_DONE;
         S_WAIT_DONE: if (done_s_q)  state_d = S_COMPLETE;
         S_COMPLETE: begin
            set_pend_c = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_q == S_LAUNCH || state_q == S_WAIT_LOW || state_q == S_WAIT_DONE) begin
         tcnt_d = tcnt_q + TW'(1);
         if (tcnt_q == TW'(TIMEOUT - 1)) begin
            state_d   = S_IDLE;
            set_err_c = 1'b1;
         end
      end
   end

   // Sequencer state and engine-facing outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         opt_scn_q   <= '0;
         lcnt_q      <= '0;
         tcnt_q      <= '0;
         init_draw_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         opt_scn_q   <= opt_scn_d;
         lcnt_q      <= lcnt_d;
         tcnt_q      <= tcnt_d;
         init_draw_q <= (state_d == S_LAUNCH);
      end
   end

   // Register read mux
   always_comb begin
      rdata_c = '0;
      case (reg_sel_c)
         2'd0: rdata_c = {28'd0, opt_scn_q};
         2'd1: rdata_c = {20'd0, 4'(level_q), 2'b00, ovf_q, pend_q, err_q,
                          empty_c, full_c, (state_q != S_IDLE)};
         2'd2: rdata_c = {29'd0, auto_en_rd_c, 1'b0, irq_en_q};
         default: rdata_c = {8'd0, period_rd_c};
      endcase
   end

   // Bus handshake, sticky status bits, control and interrupt
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         err_q    <= 1'b0;
         pend_q   <= 1'b0;
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         ack_q <= req_c;
         dat_q <= req_c ? rdata_c : 32'd0;
         if (wr_stat_c && wb_dat_i[3]) err_q  <= 1'b0;
         if (wr_stat_c && wb_dat_i[4]) pend_q <= 1'b0;
         if (wr_stat_c && wb_dat_i[5]) ovf_q  <= 1'b0;
         if (set_err_c)  err_q  <= 1'b1;
         if (set_pend_c) pend_q <= 1'b1;
         if (wr_cmd_c && !flush_c && full_c && !pop_c) ovf_q <= 1'b1;
         if (wr_ctrl_c) irq_en_q <= wb_dat_i[0];
         irq_q <= irq_en_q & (pend_q | err_q);
      end
   end

endmodule

// File: tb/tb_wb_scn_sequencer.sv
// Directed bench for wb_scn_sequencer (default build, TIMEOUT=1000).
module tb_wb_scn_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
   logic [3:0]  opt_scn;
   logic        init_draw, done_draw, irq;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int launch_n = 0;
   int last_launch = 0;
   int prev_launch = 0;
   logic init_prev = 1'b0;

   wb_scn_sequencer #(.FIFO_DEPTH(4), .INIT_CYCLES(8), .TIMEOUT(1000)) dut (
      .clk(clk), .reset(reset),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i),
      .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
      .opt_scn(opt_scn), .init_draw(init_draw), .done_draw(done_draw), .irq(irq)
   );

   always #5 clk = ~clk;

   // Cycle counter and launch monitor (records the cycle of each init_draw rise)
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (init_draw && !init_prev) begin
         launch_n    <= launch_n + 1;
         prev_launch <= last_launch;
         last_launch <= cyc;
      end
      init_prev <= init_draw;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wb_write_sel(input logic [3:0] a, input logic [31:0] d, input logic [3:0] sel);
      wb_adr_i = a; wb_dat_i = d; wb_sel_i = sel;
      wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
      @(posedge clk); #1;
      check("wr_ack", 32'(wb_ack_o), 32'd1);
      @(posedge clk); #1;
      wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
   endtask

   task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
      wb_write_sel(a, d, 4'hF);
   endtask

   task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
      wb_adr_i = a; wb_sel_i = 4'hF;
      wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
      @(posedge clk); #1;
      check("rd_ack", 32'(wb_ack_o), 32'd1);
      d = wb_dat_o;
      @(posedge clk); #1;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
   endtask

   task automatic wait_init_high(input string tag);
      for (int i = 0; i < 2000 && init_draw !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      check(tag, 32'(init_draw), 32'd1);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [31:0] d;
   int n;
   int n0;

   initial begin
      reset = 1'b1; done_draw = 1'b0;
      wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
      wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      wait_cycles(2);
      check("rst_ack",  32'(wb_ack_o),  32'd0);
      check("rst_dat",  wb_dat_o,       32'd0);
      check("rst_opt",  32'(opt_scn),   32'd0);
      check("rst_init", 32'(init_draw), 32'd0);
      check("rst_irq",  32'(irq),       32'd0);
      reset = 1'b0;
      wait_cycles(1);
      wb_read(4'h4, d); check("rst_status", d, 32'h004);
      wb_read(4'h8, d); check("rst_ctrl",   d, 32'h000);

      // Slideshow disabled: PERIOD reads 0, CTRL bit2 reads 0
      wb_write(4'hC, 32'h123456);
      wb_read(4'hC, d); check("period_off", d, 32'h0);
      wb_write(4'h8, 32'h5);
      wb_read(4'h8, d); check("ctrl_auto_off", d, 32'h1);

      // Write with byte lane 0 disabled has no effect
      wb_write_sel(4'h0, 32'h3, 4'hE);
      wait_cycles(3);
      wb_read(4'h4, d); check("sel0_status", d, 32'h004);
      check("sel0_nolaunch", 32'(launch_n), 32'd0);

      // Single screen: 8-cycle launch, done 500 cycles later, irq timing
      wb_write(4'h0, 32'h3);
      wait_init_high("t1_launch");
      check("t1_opt", 32'(opt_scn), 32'h3);
      n = 0;
      while (init_draw === 1'b1 && n < 50) begin
         n++;
         @(posedge clk); #1;
      end
      check("t1_init_len", 32'(n), 32'd8);
      wb_read(4'h4, d); check("t1_busy", d, 32'h005);
      wait_cycles(495);
      done_draw = 1'b1;
      wait_cycles(4);
      check("t1_irq_k4", 32'(irq), 32'd0);
      wait_cycles(1);
      check("t1_irq_k5", 32'(irq), 32'd1);
      wb_read(4'h4, d); check("t1_done", d, 32'h014);
      check("t1_opt_hold", 32'(opt_scn), 32'h3);
      wb_write(4'h4, 32'h10);
      wb_read(4'h4, d); check("t1_w1c", d, 32'h004);
      check("t1_irq_clr", 32'(irq), 32'd0);

      // Stale done held high: must pass through WAIT_LOW before completing
      wb_write(4'h0, 32'h7);
      wait_init_high("t3_launch");
      check("t3_opt", 32'(opt_scn), 32'h7);
      wait_cycles(60);
      wb_read(4'h4, d); check("t3_wait_low", d, 32'h005);
      check("t3_no_irq", 32'(irq), 32'd0);
      done_draw = 1'b0;
      wait_cycles(10);
      wb_read(4'h4, d); check("t3_wait_done", d, 32'h005);
      done_draw = 1'b1;
      wait_cycles(10);
      wb_read(4'h4, d); check("t3_done", d, 32'h014);
      check("t3_irq", 32'(irq), 32'd1);
      wb_write(4'h4, 32'h10);

      // Stalled engine: fill FIFO, overflow, then timeout relaunches next entry
      done_draw = 1'b0;
      wb_write(4'h0, 32'h1);
      wait_init_high("t4_launch");
      check("t4_opt1", 32'(opt_scn), 32'h1);
      wb_write(4'h0, 32'h2);
      wb_write(4'h0, 32'h3);
      wb_write(4'h0, 32'h4);
      wb_write(4'h0, 32'h5);
      wb_read(4'h4, d); check("t4_full", d, 32'h403);
      wb_write(4'h0, 32'h6);
      wb_read(4'h4, d); check("t4_overflow", d, 32'h423);
      n0 = launch_n;
      for (int i = 0; i < 1500 && launch_n == n0; i++) begin
         @(posedge clk); #1;
      end
      check("t4_relaunch", 32'(launch_n), 32'(n0 + 1));
      check("t4_timeout_cycles", 32'(last_launch - prev_launch), 32'd1001);
      check("t4_opt2", 32'(opt_scn), 32'h2);
      wb_read(4'h4, d); check("t4_status", d, 32'h329);
      check("t4_irq", 32'(irq), 32'd1);

      // Flush during screen 2: queue discarded, screen 2 still completes
      wb_write(4'h4, 32'h38);
      wb_write(4'h8, 32'h3);
      wb_read(4'h4, d); check("fl_status", d, 32'h005);
      wb_read(4'h8, d); check("fl_ctrl", d, 32'h001);
      done_draw = 1'b1;
      wait_cycles(10);
      wb_read(4'h4, d); check("fl_done", d, 32'h014);
      check("fl_opt", 32'(opt_scn), 32'h2);
      check("fl_irq", 32'(irq), 32'd1);
      check("fl_nolaunch", 32'(launch_n), 32'(n0 + 1));

      // Reset mid-WAIT_DONE: outputs drop without waiting for a clock
      done_draw = 1'b0;
      wb_write(4'h0, 32'h9);
      wait_init_high("rw_launch");
      check("rw_opt", 32'(opt_scn), 32'h9);
      wait_cycles(20);
      #3 reset = 1'b1;
      #1;
      check("rw_opt_rst",  32'(opt_scn),   32'h0);
      check("rw_irq_rst",  32'(irq),       32'd0);
      check("rw_init_rst", 32'(init_draw), 32'd0);
      #2 reset = 1'b0;
      wait_cycles(1);
      wb_read(4'h4, d); check("rw_status", d, 32'h004);
      wb_read(4'h8, d); check("rw_ctrl",   d, 32'h000);

      // Reset during LAUNCH drops init_draw asynchronously
      wb_write(4'h0, 32'hA);
      wait_init_high("rl_launch");
      wait_cycles(1);
      check("rl_init_hi", 32'(init_draw), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rl_init_rst", 32'(init_draw), 32'd0);
      #1 reset = 1'b0;
      wait_cycles(1);
      wb_read(4'h4, d); check("rl_status", d, 32'h004);

      // Index truncates to 4 bits
      wb_write(4'h0, 32'h1F);
      wait_init_high("wrap_launch");
      check("wrap_opt", 32'(opt_scn), 32'hF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
